mem_wb_stage: RTL

- Parametrised MEM->WB pipeline stage register; next generation of the plain MEM/WB latch.
- Adds a valid/ready handshake, stall back-pressure, flush, optional skid buffer, and a forwarding tap for the hazard unit.
- Sits between the data-memory stage and register-file writeback.
- Widths are generic, so the same block serves RV32 and RV64 builds.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_slot.sv | 36 +++
 rtl/mem_wb_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the MEM->WB pipeline stage.
// The payload is packed as {memtoreg, regwrite, memdata, aluresult, rd}, MSB first.
package pipe_pkg;

    localparam int unsigned PIPE_XLEN = 64;
    localparam int unsigned PIPE_RD_W = 5;

    typedef struct packed {
        logic                 memtoreg;
        logic                 regwrite;
        logic [PIPE_XLEN-1:0] memdata;
        logic [PIPE_XLEN-1:0] aluresult;
        logic [PIPE_RD_W-1:0] rd;
    } wb_payload_t;

    localparam int unsigned WB_PAYLOAD_W = $bits(wb_payload_t);

    // Flattened payload width for non-default XLEN/RD_W builds; same field order as wb_payload_t.
    function automatic int unsigned payload_width(input int unsigned xlen, input int unsigned rd_w);
        return 2 + 2 * xlen + rd_w;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline payload register with its valid bit.
// clear dominates load; the payload only updates when a valid entry is loaded.
module pipe_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic         load_valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= load_valid_i;
            if (load_valid_i) begin
                data_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB stage register with valid/ready handshake, flush, optional skid slot
// and a forwarding tap for the hazard unit.
module mem_wb_stage
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN    = PIPE_XLEN,
    parameter int unsigned RD_W    = PIPE_RD_W,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_memtoreg,
    input  logic            in_regwrite,
    input  logic [XLEN-1:0] in_memdata,
    input  logic [XLEN-1:0] in_aluresult,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_memtoreg,
    output logic            out_regwrite,
    output logic [XLEN-1:0] out_memdata,
    output logic [XLEN-1:0] out_aluresult,
    output logic [RD_W-1:0] out_rd,
    output logic            fwd_valid,
    output logic [RD_W-1:0] fwd_rd,
    output logic [XLEN-1:0] fwd_data
);

    localparam int unsigned PW = payload_width(XLEN, RD_W);

    logic [PW-1:0] in_payload;
    logic [PW-1:0] out_payload;
    logic [PW-1:0] out_load_data;
    logic [PW-1:0] skid_payload;
    logic          skid_valid;
    logic          out_free;
    logic          accept;
    logic          out_load_valid;
    logic          skid_load;
    logic          skid_load_valid;
    logic          skid_valid_next;
    logic          ready_q;
    logic          ready_d;
    logic          regwrite_q;

    assign in_payload = {in_memtoreg, in_regwrite, in_memdata, in_aluresult, in_rd};

    always_comb begin
        out_free        = !out_valid || out_ready;
        accept          = in_valid && in_ready && !flush;
        skid_load       = 1'b0;
        skid_load_valid = 1'b0;
        if (SKID_EN) begin
            // Input parks in the skid only when the output slot cannot take it this edge.
            skid_load       = (accept && !out_free) || (out_free && skid_valid);
            skid_load_valid = accept && !out_free;
        end
        out_load_valid  = skid_valid || accept;
        out_load_data   = skid_valid ? skid_payload : in_payload;
        skid_valid_next = flush ? 1'b0 : (skid_load ? skid_load_valid : skid_valid);
        ready_d         = SKID_EN ? !skid_valid_next : 1'b1;
    end

    // With SKID_EN=0 this only marks the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
        end
    end

    assign in_ready = SKID_EN ? ready_q : (ready_q && out_free);

    pipe_slot #(.W(PW)) u_out_slot (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (flush),
        .load_i       (out_free),
        .load_valid_i (out_load_valid),
        .data_i       (out_load_data),
        .valid_o      (out_valid),
        .data_o       (out_payload)
    );

    if (SKID_EN) begin : g_skid
        pipe_slot #(.W(PW)) u_skid_slot (
            .clk          (clk),
            .rst_n        (rst_n),
            .clear_i      (flush),
            .load_i       (skid_load),
            .load_valid_i (skid_load_valid),
            .data_i       (in_payload),
            .valid_o      (skid_valid),
            .data_o       (skid_payload)
        );
    end else begin : g_no_skid
        assign skid_valid   = 1'b0;
        assign skid_payload = '0;
    end

    assign out_memtoreg  = out_payload[PW-1];
    assign regwrite_q    = out_payload[PW-2];
    assign out_memdata   = out_payload[PW-3 -: XLEN];
    assign out_aluresult = out_payload[RD_W +: XLEN];
    assign out_rd        = out_payload[RD_W-1:0];

    // Stale payload after a flush must never look like a live register write.
    assign out_regwrite = regwrite_q && out_valid;
    assign fwd_valid    = out_regwrite && (out_rd != '0);
    assign fwd_rd       = out_rd;
    assign fwd_data     = out_memtoreg ? out_memdata : out_aluresult;

endmodule
